// File: rtl/btn_debouncer_pkg.sv
// Package: btn_debouncer_pkg
// Purpose: shared FSM state encoding, board clock-rate constant and the
//          default cycle counts derived from it for the button debouncer.
//          Imported by the interface and the RTL modules.
// Contents:
//   state_t                 2-bit FSM state (S_IDLE, S_PQUAL, S_PRESSED, S_RQUAL)
//   CLK_HZ                  board clock rate
//   DEF_DEBOUNCE_CYCLES     10 ms of stable input at CLK_HZ
//   DEF_LONG_CYCLES         1 s of hold at CLK_HZ
//   PRESS_CNT_W             width of the press counter (drives led[7:3])
//   is_level_state()        debounced level implied by a state
package btn_debouncer_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,   // released and stable
        S_PQUAL   = 2'd1,   // synced input high, qualifying a press
        S_PRESSED = 2'd2,   // accepted press, counting hold time
        S_RQUAL   = 2'd3    // synced input low, qualifying a release
    } state_t;

    localparam int unsigned CLK_HZ              = 100_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;   // 10 ms
    localparam int unsigned DEF_LONG_CYCLES     = CLK_HZ;         // 1 s
    localparam int          PRESS_CNT_W         = 5;

    // The debounced level stays high while a release is still being
    // qualified, so a short low glitch never reaches btn_level.
    function automatic logic is_level_state(input state_t s);
        return (s == S_PRESSED) || (s == S_RQUAL);
    endfunction

endpackage

// File: rtl/btn_debouncer_if.sv
// Interface: btn_debouncer_if
// Purpose: bundles the raw button input and the conditioned outputs of one
//          debouncer channel, plus the FSM state for observation.
// Signals:
//   btnp       raw asynchronous button (driven by the master side)
//   btn_level  debounced level
//   btn_rise   one-cycle pulse on accepted press
//   btn_fall   one-cycle pulse on accepted release
//   btn_long   one-cycle pulse when a press has been held long enough
//   press_cnt  accepted-press count, modulo 32
//   state      current debouncer FSM state
// Modports:
//   slave   the debouncer (consumes btnp, produces everything else)
//   master  the environment driving the button and watching the outputs
// Handshake: there is no valid/ready pair here; every output is a registered
//   level or a single-cycle pulse and the consumer cannot apply backpressure,
//   so a pulse must be sampled in the cycle it is high.
interface btn_debouncer_if;
    import btn_debouncer_pkg::*;

    logic                   btnp;
    logic                   btn_level;
    logic                   btn_rise;
    logic                   btn_fall;
    logic                   btn_long;
    logic [PRESS_CNT_W-1:0] press_cnt;
    state_t                 state;

    modport slave (
        input  btnp,
        output btn_level, btn_rise, btn_fall, btn_long, press_cnt, state
    );

    modport master (
        output btnp,
        input  btn_level, btn_rise, btn_fall, btn_long, press_cnt, state
    );

endinterface

// File: rtl/btn_debouncer_sync_2ff.sv
// Module: sync_2ff
// Purpose: generic 1-bit two-flop synchroniser with synchronous active-high
//          reset, for bringing an asynchronous input into the clk domain.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous, active-high reset (clears both flops)
//   d    in  asynchronous input
//   q    out synchronised output (two clk edges of latency)
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/btn_debouncer.sv
// Module: btn_debouncer
// Purpose: conditions one raw push-button. The input is synchronised with
//          two flops and a four-state FSM accepts a press or release only
//          after DEBOUNCE_CYCLES consecutive stable synced samples. Emits a
//          clean level, one-cycle rise/fall/long pulses and a 5-bit count of
//          accepted presses.
// Parameters:
//   DEBOUNCE_CYCLES  stable synced samples needed to accept a change
//   LONG_CYCLES      held cycles after an accepted press before btn_long
// Ports:
//   clk  in   system clock
//   rst  in   synchronous, active-high reset
//   bus  slave modport of btn_debouncer_if (btnp in; level, pulses,
//        press_cnt and FSM state out)
// Timing: btnp first sampled high at edge e0 gives btn_rise and btn_level
//   high after edge e0+DEBOUNCE_CYCLES+2; release behaves the same way for
//   btn_fall. btn_long fires LONG_CYCLES counted edges after the rise edge.
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    btn_debouncer_if.slave  bus
);

    // Both counters share one width sized for the hold count; the
    // qualify count is assumed never to exceed the hold count.
    localparam int CNT_W = $clog2(LONG_CYCLES) + 1;

    localparam logic [CNT_W-1:0] Q_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                   s2;

    state_t                 state_q,     state_d;
    logic [CNT_W-1:0]       qcnt_q,      qcnt_d;
    logic [CNT_W-1:0]       hcnt_q,      hcnt_d;
    logic                   long_seen_q, long_seen_d;
    logic [PRESS_CNT_W-1:0] press_q,     press_d;
    logic                   rise_q,      rise_d;
    logic                   fall_q,      fall_d;
    logic                   long_q,      long_d;
    logic                   level_q;

    // The FSM only ever sees the synchronised copy of the button.
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.btnp),
        .q   (s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            qcnt_q      <= '0;
            hcnt_q      <= '0;
            long_seen_q <= 1'b0;
            press_q     <= '0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            long_q      <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            hcnt_q      <= hcnt_d;
            long_seen_q <= long_seen_d;
            press_q     <= press_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            long_q      <= long_d;
            // Registered from the next state so the level changes on the
            // same edge as the rise/fall pulse.
            level_q     <= is_level_state(state_d);
        end
    end

    always_comb begin
        state_d     = state_q;
        qcnt_d      = qcnt_q;
        hcnt_d      = hcnt_q;
        long_seen_d = long_seen_q;
        press_d     = press_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (s2) begin
                    state_d = S_PQUAL;
                    qcnt_d  = '0;
                end
            end

            S_PQUAL: begin
                if (!s2) begin
                    // Bounce: drop back silently.
                    state_d = S_IDLE;
                end else if (qcnt_q == Q_LAST) begin
                    state_d     = S_PRESSED;
                    rise_d      = 1'b1;
                    press_d     = press_q + PRESS_CNT_W'(1);
                    hcnt_d      = '0;
                    long_seen_d = 1'b0;
                end else begin
                    qcnt_d = qcnt_q + CNT_ONE;
                end
            end

            S_PRESSED: begin
                if (!s2) begin
                    // Hold count is frozen while the release qualifies.
                    state_d = S_RQUAL;
                    qcnt_d  = '0;
                end else if (hcnt_q == H_LAST) begin
                    // hcnt saturates here; long_seen limits the pulse to
                    // once per press even across release glitches.
                    if (!long_seen_q) begin
                        long_d      = 1'b1;
                        long_seen_d = 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + CNT_ONE;
                end
            end

            S_RQUAL: begin
                if (s2) begin
                    // Release glitch: resume the same press.
                    state_d = S_PRESSED;
                end else if (qcnt_q == Q_LAST) begin
                    state_d = S_IDLE;
                    fall_d  = 1'b1;
                end else begin
                    qcnt_d = qcnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.btn_level = level_q;
    assign bus.btn_rise  = rise_q;
    assign bus.btn_fall  = fall_q;
    assign bus.btn_long  = long_q;
    assign bus.press_cnt = press_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_btn_debouncer.sv
// Testbench: tb_btn_debouncer
// Purpose: directed check of btn_debouncer with DEBOUNCE_CYCLES=4 and
//          LONG_CYCLES=20. Edges are numbered by cyc (edge k sets cyc=k);
//          inputs change and outputs are checked on the falling edge, so a
//          btnp change made when cyc==k is first sampled at edge k+1.
module tb_btn_debouncer;
    import btn_debouncer_pkg::*;

    localparam int DEB = 4;
    localparam int LNG = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    btn_debouncer_if bus ();

    btn_debouncer #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- pulse monitor ----------------
    int rise_n = 0, fall_n = 0, long_n = 0, overlap_n = 0;
    int rise_cyc = 0, fall_cyc = 0, long_cyc = 0;

    always @(posedge clk) begin
        #2;
        if (bus.btn_rise === 1'b1) begin rise_n++; rise_cyc = cyc; end
        if (bus.btn_fall === 1'b1) begin fall_n++; fall_cyc = cyc; end
        if (bus.btn_long === 1'b1) begin long_n++; long_cyc = cyc; end
        if ((int'(bus.btn_rise) + int'(bus.btn_fall) + int'(bus.btn_long)) > 1)
            overlap_n++;
    end

    // ---------------- checking ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic to_edge(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    int t, e0, f, r_edge, g, r0, f0, l0;

    initial begin
        bus.btnp = 1'b0;
        rst      = 1'b1;
        tick(3);

        // 1: reset with button low, then held high through reset
        check("rst_level", 32'(bus.btn_level), 0);
        check("rst_rise",  32'(bus.btn_rise),  0);
        check("rst_fall",  32'(bus.btn_fall),  0);
        check("rst_long",  32'(bus.btn_long),  0);
        check("rst_cnt",   32'(bus.press_cnt), 0);
        check("rst_state", 32'(bus.state),     32'(S_IDLE));
        bus.btnp = 1'b1;
        tick(8);
        check("rst_hold_level", 32'(bus.btn_level), 0);
        check("rst_hold_cnt",   32'(bus.press_cnt), 0);
        check("rst_hold_rises", rise_n, 0);
        check("rst_hold_state", 32'(bus.state), 32'(S_IDLE));

        // Button still high when reset drops: first free edge t+1 samples it
        rst = 1'b0;
        t   = cyc;
        to_edge(t + 6);
        check("held_no_early_rise", rise_n, 0);
        to_edge(t + 7);
        check("held_rise",     32'(bus.btn_rise),  1);
        check("held_cnt",      32'(bus.press_cnt), 1);
        check("held_rise_cyc", rise_cyc, t + 7);

        bus.btnp = 1'b0;
        rst      = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(10);
        check("restart_cnt",   32'(bus.press_cnt), 0);
        check("restart_level", 32'(bus.btn_level), 0);

        // 2: clean press held 12 cycles, then release
        r0 = rise_n; f0 = fall_n; l0 = long_n;
        bus.btnp = 1'b1;
        e0 = cyc + 1;
        to_edge(e0 + 5);
        check("clean_level_pre", 32'(bus.btn_level), 0);
        check("clean_rise_pre",  32'(bus.btn_rise),  0);
        to_edge(e0 + 6);
        check("clean_rise",  32'(bus.btn_rise),  1);
        check("clean_level", 32'(bus.btn_level), 1);
        check("clean_cnt",   32'(bus.press_cnt), 1);
        check("clean_state", 32'(bus.state),     32'(S_PRESSED));
        to_edge(e0 + 7);
        check("clean_rise_width", 32'(bus.btn_rise), 0);
        to_edge(e0 + 11);
        bus.btnp = 1'b0;
        f = e0 + 12;
        to_edge(f + 5);
        check("clean_level_hold", 32'(bus.btn_level), 1);
        check("clean_no_early_fall", fall_n, f0);
        to_edge(f + 6);
        check("clean_fall",      32'(bus.btn_fall),  1);
        check("clean_level_rel", 32'(bus.btn_level), 0);
        tick(2);
        check("clean_rise_count", rise_n,   r0 + 1);
        check("clean_fall_count", fall_n,   f0 + 1);
        check("clean_fall_cyc",   fall_cyc, f + 6);
        check("clean_no_long",    long_n,   l0);

        // 3: bounce, 5 x (3 high, 2 low), then low
        r0 = rise_n;
        for (int i = 0; i < 5; i++) begin
            bus.btnp = 1'b1;
            tick(3);
            bus.btnp = 1'b0;
            tick(2);
        end
        tick(10);
        check("bounce_no_rise", rise_n, r0);
        check("bounce_level",   32'(bus.btn_level), 0);
        check("bounce_cnt",     32'(bus.press_cnt), 1);
        check("bounce_state",   32'(bus.state),     32'(S_IDLE));

        // 4: long press held 30 cycles after rise
        l0 = long_n; f0 = fall_n;
        bus.btnp = 1'b1;
        e0     = cyc + 1;
        r_edge = e0 + 6;
        to_edge(r_edge);
        check("long_rise", 32'(bus.btn_rise),  1);
        check("long_cnt",  32'(bus.press_cnt), 2);
        to_edge(r_edge + 19);
        check("long_not_early", long_n, l0);
        to_edge(r_edge + 20);
        check("long_pulse", 32'(bus.btn_long), 1);
        to_edge(r_edge + 21);
        check("long_width", 32'(bus.btn_long), 0);
        to_edge(r_edge + 29);
        bus.btnp = 1'b0;
        to_edge(r_edge + 38);
        check("long_once",       long_n,   l0 + 1);
        check("long_cyc",        long_cyc, r_edge + 20);
        check("long_fall_count", fall_n,   f0 + 1);
        check("long_level_rel",  32'(bus.btn_level), 0);

        // 5: release glitch of 3 cycles before and after the long pulse
        l0 = long_n; f0 = fall_n;
        bus.btnp = 1'b1;
        e0     = cyc + 1;
        r_edge = e0 + 6;
        to_edge(r_edge + 4);
        bus.btnp = 1'b0;
        g = r_edge + 5;
        tick(3);
        bus.btnp = 1'b1;
        to_edge(g + 4);
        check("glitch_state_rqual", 32'(bus.state),     32'(S_RQUAL));
        check("glitch_level",       32'(bus.btn_level), 1);
        to_edge(g + 5);
        check("glitch_state_back", 32'(bus.state), 32'(S_PRESSED));
        // hcnt counts edges R+1..R+6, then the edge that sees the low input
        // and the three RQUAL edges (R+7..R+10) are not counted.
        to_edge(r_edge + 23);
        check("glitch_long_not_early", long_n, l0);
        to_edge(r_edge + 24);
        check("glitch_long_pulse", 32'(bus.btn_long), 1);
        to_edge(r_edge + 27);
        bus.btnp = 1'b0;
        tick(3);
        bus.btnp = 1'b1;
        to_edge(r_edge + 31);
        check("glitch2_state", 32'(bus.state),     32'(S_RQUAL));
        check("glitch2_level", 32'(bus.btn_level), 1);
        to_edge(r_edge + 45);
        check("glitch2_no_long", long_n, l0 + 1);
        check("glitch_no_fall",  fall_n, f0);
        check("glitch2_level_after", 32'(bus.btn_level), 1);
        bus.btnp = 1'b0;
        to_edge(r_edge + 53);
        check("glitch_fall_count", fall_n,   f0 + 1);
        check("glitch_fall_cyc",   fall_cyc, r_edge + 52);
        check("glitch_cnt",        32'(bus.press_cnt), 3);

        // 6: counter wrap over 33 presses, then reset during qualification
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        check("wrap_start", 32'(bus.press_cnt), 0);
        for (int i = 0; i < 33; i++) begin
            bus.btnp = 1'b1;
            e0 = cyc + 1;
            to_edge(e0 + 6);
            check($sformatf("wrap_rise_%0d", i), 32'(bus.btn_rise), 1);
            check($sformatf("wrap_cnt_%0d", i), 32'(bus.press_cnt), (i + 1) % 32);
            to_edge(e0 + 7);
            bus.btnp = 1'b0;
            to_edge(e0 + 16);
        end
        check("wrap_end_cnt", 32'(bus.press_cnt), 1);

        r0 = rise_n;
        bus.btnp = 1'b1;
        e0 = cyc + 1;
        to_edge(e0 + 3);
        check("pqual_state", 32'(bus.state), 32'(S_PQUAL));
        rst      = 1'b1;
        bus.btnp = 1'b0;
        tick(2);
        check("pqual_rst_cnt",   32'(bus.press_cnt), 0);
        check("pqual_rst_state", 32'(bus.state),     32'(S_IDLE));
        rst = 1'b0;
        tick(12);
        check("pqual_no_rise", rise_n, r0);
        check("pqual_level",   32'(bus.btn_level), 0);
        check("pqual_cnt",     32'(bus.press_cnt), 0);
        check("no_pulse_overlap", overlap_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
